// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction-fetch handshake for the RV32I core.
// Optional macro PC_FETCH_TIMEOUT_EN traps fetches that wait MAX_WAIT cycles without imem_ack.
module pc_fetch_ctrl #(
  localparam int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
`ifdef PC_FETCH_TIMEOUT_EN
  ,
  parameter int unsigned MAX_WAIT = 15
`endif
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_load,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            fault;
  logic            fault_d;
  logic            capture;
  logic            count_inc;
  logic            timeout;
  logic            misaligned;
  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] redirect_pc;

  // Misaligned redirect targets are replaced by the trap vector.
  assign misaligned  = |redirect_target[1:0];
  assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  assign waiting = ((state == REQ) || (state == FLUSH)) && !imem_ack;
  assign timeout = waiting && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Counts consecutive un-acked cycles of the current request; restarts on every state entry.
  always_ff @(posedge clk) begin
    if (!areset || !waiting || timeout || (state_d != state)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state plus the Mealy pc_reg load controls.
  always_comb begin
    state_d   = state;
    pc_load   = 1'b0;
    next_pc   = '0;
    fault_d   = 1'b0;
    capture   = 1'b0;
    count_inc = 1'b0;
    addr_d    = imem_addr;
    case (state)
      BOOT: begin
        pc_load = 1'b1;
        next_pc = RESET_VECTOR;
        addr_d  = RESET_VECTOR;
        state_d = REQ;
      end
      REQ, FLUSH: begin
        if (redirect) begin
          pc_load = 1'b1;
          next_pc = redirect_pc;
          fault_d = misaligned;
          // An un-acked request must still complete before the new fetch can start.
          if (imem_ack) begin
            state_d = REQ;
            addr_d  = redirect_pc;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          if (state == REQ) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = REQ;
            addr_d  = pc;
          end
        end else if (timeout) begin
          pc_load = 1'b1;
          next_pc = TRAP_VECTOR;
          fault_d = 1'b1;
          addr_d  = TRAP_VECTOR;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          next_pc = redirect_pc;
          fault_d = misaligned;
          addr_d  = redirect_pc;
          state_d = REQ;
        end else if (if_ready) begin
          pc_load   = 1'b1;
          next_pc   = pc + XLEN'(4);
          addr_d    = pc + XLEN'(4);
          count_inc = 1'b1;
          state_d   = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (!areset) begin
      pc_load = 1'b0;
      next_pc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state       <= BOOT;
      fault       <= 1'b0;
      imem_addr   <= '0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      state     <= state_d;
      fault     <= fault_d;
      imem_addr <= addr_d;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
      if (count_inc) begin
        fetch_count <= fetch_count + XLEN'(1);
      end
    end
  end

  assign imem_req    = (state == REQ) || (state == FLUSH);
  assign if_valid    = (state == HOLD);
  assign fetch_fault = fault;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: pc_reg and imem models, queue of expected fetch addresses.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] pc_q = 32'hDEAD_BEEF;
  logic        pc_load;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic        ack_auto;
  logic        ack_man;
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // Instruction memory: acks when enabled, returns an address-derived word.
  assign imem_ack   = imem_req && (ack_auto || ack_man);
  assign imem_rdata = mem_word(imem_addr);

  // pc_reg model.
  always @(posedge clk) if (pc_load) pc_q <= next_pc;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .areset          (areset),
    .pc              (pc_q),
    .pc_load         (pc_load),
    .next_pc         (next_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until n instructions are accepted by decode, scoring each against the queue.
  task automatic run_accepts(input int n, input int budget);
    int got = 0;
    logic [31:0] e;
    for (int c = 0; c < budget && got < n; c++) begin
      #1;
      if (imem_req) check("imem_addr_eq_pc", imem_addr, pc_q);
      if (if_valid && if_ready && !redirect) begin
        if (sb.size() == 0) begin
          e = 32'hFFFF_FFFF;
          check("unexpected_accept", if_pc, e);
        end else begin
          e = sb.pop_front();
          check("accept_pc", if_pc, e);
          check("accept_instr", if_instr, mem_word(e));
          check("accept_pc_load", {31'd0, pc_load}, 32'd1);
          check("accept_next_pc", next_pc, e + 32'd4);
        end
        got++;
        exp_count++;
      end
      tick();
    end
    check("accept_budget", got, n);
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    #1;
    while (!if_valid && c < budget) begin
      tick();
      #1;
      c++;
    end
    check("wait_valid", {31'd0, if_valid}, 32'd1);
  endtask

  initial begin
    areset = 1'b0;
    if_ready = 1'b1;
    redirect = 1'b0;
    redirect_target = '0;
    ack_auto = 1'b1;
    ack_man = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);
    check("rst_next_pc", next_pc, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);

    // Boot, then sequential fetches at 0, 4, 8
    areset = 1'b1;
    #1;
    check("boot_pc_load", {31'd0, pc_load}, 32'd1);
    check("boot_next_pc", next_pc, 32'h0000_0000);
    tick();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    run_accepts(3, 20);
    check("count_after_3", fetch_count, 32'd3);

    // Stall in HOLD for 5 cycles
    if_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_if_pc", if_pc, 32'hC);
      check("stall_if_instr", if_instr, mem_word(32'hC));
      check("stall_pc_load", {31'd0, pc_load}, 32'd0);
      tick();
      #1;
    end
    if_ready = 1'b1;
    sb.push_back(32'hC);
    run_accepts(1, 5);

    // Redirect during HOLD drops the held instruction
    if_ready = 1'b0;
    wait_valid(10);
    redirect = 1'b1;
    redirect_target = 32'h0000_0040;
    if_ready = 1'b1;
    #1;
    check("hold_redir_pc_load", {31'd0, pc_load}, 32'd1);
    check("hold_redir_next_pc", next_pc, 32'h40);
    tick();
    redirect = 1'b0;
    check("hold_redir_count", fetch_count, exp_count);
    check("hold_redir_addr", imem_addr, 32'h40);
    sb.push_back(32'h40);
    run_accepts(1, 10);

    // Redirect in REQ with ack delayed 3 cycles -> FLUSH
    ack_auto = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h0000_0080;
    #1;
    check("req_redir_pc_load", {31'd0, pc_load}, 32'd1);
    check("req_redir_next_pc", next_pc, 32'h80);
    tick();
    redirect = 1'b0;
    check("flush_req", {31'd0, imem_req}, 32'd1);
    check("flush_old_addr", imem_addr, 32'h44);
    tick();
    check("flush_no_valid", {31'd0, if_valid}, 32'd0);
    check("flush_old_addr2", imem_addr, 32'h44);
    tick();
    ack_man = 1'b1;
    #1;
    check("flush_ack_no_load", {31'd0, pc_load}, 32'd0);
    tick();
    ack_man = 1'b0;
    ack_auto = 1'b1;
    check("post_flush_addr", imem_addr, 32'h80);
    sb.push_back(32'h80);
    run_accepts(1, 10);

    // Misaligned redirect traps
    if_ready = 1'b0;
    wait_valid(10);
    redirect = 1'b1;
    redirect_target = 32'h0000_0042;
    if_ready = 1'b1;
    #1;
    check("mis_next_pc", next_pc, 32'h100);
    check("mis_pc_load", {31'd0, pc_load}, 32'd1);
    check("mis_fault_pre", {31'd0, fetch_fault}, 32'd0);
    tick();
    redirect = 1'b0;
    check("mis_fault_pulse", {31'd0, fetch_fault}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
    tick();
    check("mis_fault_end", {31'd0, fetch_fault}, 32'd0);
    check("mis_count", fetch_count, exp_count);
    sb.push_back(32'h100);
    run_accepts(1, 10);

    // PC+4 wraps from 0xFFFF_FFFC to 0
    if_ready = 1'b0;
    wait_valid(10);
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    check("wrap_redir_next_pc", next_pc, 32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    if_ready = 1'b1;
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    run_accepts(2, 12);
    check("count_before_reset", fetch_count, exp_count);

    // Reset while a request is outstanding
    ack_auto = 1'b0;
    tick();
    tick();
    check("stuck_req", {31'd0, imem_req}, 32'd1);
    areset = 1'b0;
    tick();
    check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
    check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    check("midrst_pc_load", {31'd0, pc_load}, 32'd0);
    check("midrst_next_pc", next_pc, 32'd0);
    check("midrst_fault", {31'd0, fetch_fault}, 32'd0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_if_pc", if_pc, 32'd0);
    exp_count = 0;
    sb.delete();
    areset = 1'b1;
    ack_auto = 1'b1;
    #1;
    check("reboot_pc_load", {31'd0, pc_load}, 32'd1);
    check("reboot_next_pc", next_pc, 32'd0);
    tick();
    sb.push_back(32'h0);
    run_accepts(1, 10);
    check("reboot_count", fetch_count, exp_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
